// File: rtl/wb_regfile_if.sv
// Write-back / register-read bundle between the MEM/WB stage, the decode stage and wb_regfile.
// The master drives the write-back and read requests; the slave is the register file.
interface wb_regfile_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              whilo;
  logic [DATA_W-1:0] hi_i;
  logic [DATA_W-1:0] lo_i;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic [15:0]       wr_count;

  modport master (
    output we, waddr, wdata, whilo, hi_i, lo_i, re1, raddr1, re2, raddr2,
    input  rdata1, rdata2, hi_o, lo_o, wr_count
  );

  modport slave (
    input  we, waddr, wdata, whilo, hi_i, lo_i, re1, raddr1, re2, raddr2,
    output rdata1, rdata2, hi_o, lo_o, wr_count
  );
endinterface

// File: rtl/wb_regfile.sv
// GPR file plus HI/LO pair fed by the MEM/WB stage, with two bypassed decode read ports
// and a bypassed HI/LO read port. Register 0 is hardwired to zero.
module wb_regfile #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32
) (
  input logic         clk,
  input logic         rst,
  wb_regfile_if.slave bus
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [15:0]       wr_count_q;

  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] hi_rd;
  logic [DATA_W-1:0] lo_rd;
  logic              gpr_wr;

  assign gpr_wr = bus.we && (bus.waddr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      hi_q       <= '0;
      lo_q       <= '0;
      wr_count_q <= '0;
    end else begin
      if (gpr_wr) begin
        regs_q[bus.waddr] <= bus.wdata;
        wr_count_q        <= wr_count_q + 16'd1;
      end
      if (bus.whilo) begin
        hi_q <= bus.hi_i;
        lo_q <= bus.lo_i;
      end
    end
  end

  // Enable is tested before the address so an undriven address cannot leak X when disabled.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (!rst && bus.re1 && (bus.raddr1 != '0)) begin
      rdata1 = (bus.we && (bus.waddr == bus.raddr1)) ? bus.wdata : regs_q[bus.raddr1];
    end
    if (!rst && bus.re2 && (bus.raddr2 != '0)) begin
      rdata2 = (bus.we && (bus.waddr == bus.raddr2)) ? bus.wdata : regs_q[bus.raddr2];
    end
  end

  always_comb begin
    hi_rd = '0;
    lo_rd = '0;
    if (!rst) begin
      hi_rd = bus.whilo ? bus.hi_i : hi_q;
      lo_rd = bus.whilo ? bus.lo_i : lo_q;
    end
  end

  assign bus.rdata1   = rdata1;
  assign bus.rdata2   = rdata2;
  assign bus.hi_o     = hi_rd;
  assign bus.lo_o     = lo_rd;
  assign bus.wr_count = wr_count_q;

endmodule
